// File: rtl/program_loader.sv
// program_loader: streams a count-prefixed program into instruction memory
// and holds the CPU in reset until the load completes. Checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wr,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [5:0]        word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [6:0] MAX_N = 7'(DEPTH);

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] ptr;
    logic [5:0]        left;
    logic [7:0]        hi;
    logic              accept;
    logic              restart;
    logic              count_ok;
    logic              last;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept   = in_valid & in_ready;
    assign count_ok = (in_data[7:6] == 2'b00) && (in_data[5:0] != 6'd0) &&
                      ({1'b0, in_data[5:0]} <= MAX_N);
    assign last     = (left == 6'd1);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        next     = state;
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        restart  = 1'b0;
        unique case (state)
            S_IDLE: begin
                restart = start;
                if (start) next = S_COUNT;
            end
            S_COUNT: begin
                in_ready = 1'b1;
                if (accept) next = count_ok ? S_HI : S_ERROR;
            end
            S_HI: begin
                in_ready = 1'b1;
                if (accept) next = S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (accept) next = last ? S_CHECK : S_HI;
`else
                if (accept) next = last ? S_DONE : S_HI;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (accept) next = (in_data == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                restart  = start;
                if (start) next = S_COUNT;
            end
            S_ERROR: begin
                err     = 1'b1;
                restart = start;
                if (start) next = S_COUNT;
            end
            default: next = S_IDLE;
        endcase
    end

    // Byte capture, word assembly and memory write issue
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            left     <= '0;
            hi       <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wr   <= 1'b0;
            word_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            mem_wr <= 1'b0;
            if (restart) begin
                ptr      <= '0;
                word_cnt <= '0;
            end
            if (accept) begin
                unique case (state)
                    S_COUNT: begin
                        left <= in_data[5:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum <= in_data;
`endif
                    end
                    S_HI: begin
                        hi <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                    end
                    S_LO: begin
                        mem_wr   <= 1'b1;
                        mem_addr <= ptr;
                        mem_data <= {hi, in_data};
                        ptr      <= ptr + ADDR_W'(1);
                        left     <= left - 6'd1;
                        word_cnt <= word_cnt + 6'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
